// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command, ALU and response signal bundle for alu_cmd_sequencer
interface alu_cmd_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [5:0] cmd_a;
   logic [5:0] cmd_b;

   logic [5:0] alu_a;
   logic [5:0] alu_b;
   logic [2:0] alu_select;
   logic [5:0] alu_returns;
   logic       alu_of;

   logic       rsp_valid;
   logic       rsp_ready;
   logic [5:0] rsp_data;
   logic       rsp_of;
   logic [2:0] rsp_op;

   logic       busy;
   logic [7:0] ovf_count;

   // master is the sequencer itself; slave is the command source, ALU and response sink
   modport master (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_returns, alu_of, rsp_ready,
      output cmd_ready, alu_a, alu_b, alu_select, rsp_valid, rsp_data, rsp_of, rsp_op,
             busy, ovf_count
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_a, cmd_b, alu_returns, alu_of, rsp_ready,
      input  cmd_ready, alu_a, alu_b, alu_select, rsp_valid, rsp_data, rsp_of, rsp_op,
             busy, ovf_count
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - queues ALU commands, issues them one at a time and returns results
module alu_cmd_sequencer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   alu_cmd_sequencer_if.master  bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_RESP    = 2'd3;

   localparam logic [2:0] SEL_PARK  = 3'b010;

   logic [14:0]      mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fifo_full, fifo_empty, push, pop;
   logic [14:0]      head;

   logic [1:0]       state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [5:0]       a_q, a_d;
   logic [5:0]       b_q, b_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [5:0]       rsp_data_q, rsp_data_d;
   logic             rsp_of_q, rsp_of_d;
   logic [2:0]       rsp_op_q, rsp_op_d;
   logic [7:0]       ovf_q, ovf_d;
   logic             reserved_op;
   logic             sampled_of;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Full is taken from the count alone, so a pop in the same cycle never opens the door
   assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (cnt_q == '0);
   assign push       = bus.cmd_valid && !fifo_full;
   assign pop        = (state_q == S_IDLE) && !fifo_empty;
   assign head       = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
      end
   end

   // Reserved op codes 010/011 still take the full slot but report a clean zero result
   assign reserved_op = (op_q[2:1] == 2'b01);
   assign sampled_of  = !reserved_op && bus.alu_of;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_of_d    = rsp_of_q;
      rsp_op_d    = rsp_op_q;
      ovf_d       = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               op_d    = head[14:12];
               a_d     = head[11:6];
               b_d     = head[5:0];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            rsp_data_d  = reserved_op ? 6'd0 : bus.alu_returns;
            rsp_of_d    = sampled_of;
            rsp_op_d    = op_q;
            rsp_valid_d = 1'b1;
            if (sampled_of && (ovf_q != 8'hFF)) begin
               ovf_d = ovf_q + 8'd1;
            end
            state_d = S_RESP;
         end
         default: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         state_q     <= S_IDLE;
         op_q        <= 3'd0;
         a_q         <= 6'd0;
         b_q         <= 6'd0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 6'd0;
         rsp_of_q    <= 1'b0;
         rsp_op_q    <= 3'd0;
         ovf_q       <= 8'd0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_of_q    <= rsp_of_d;
         rsp_op_q    <= rsp_op_d;
         ovf_q       <= ovf_d;
      end
   end

   assign bus.cmd_ready  = !fifo_full;
   assign bus.alu_a      = a_q;
   assign bus.alu_b      = b_q;
   assign bus.alu_select = ((state_q == S_ISSUE) || (state_q == S_CAPTURE)) ? op_q : SEL_PARK;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_of     = rsp_of_q;
   assign bus.rsp_op     = rsp_op_q;
   assign bus.busy       = (state_q != S_IDLE) || !fifo_empty;
   assign bus.ovf_count  = ovf_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed bench with a transaction-level response model
module tb_alu_cmd_sequencer;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [5:0] data;
      logic       of;
      logic [2:0] op;
   } rsp_t;

   logic clk;
   logic reset;
   alu_cmd_sequencer_if bus ();

   alu_cmd_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int         total = 0;
   int         bad   = 0;
   rsp_t       exp_q [$];
   logic [5:0] seen_q [$];
   int         ovf_exp = 0;
   logic       prev_valid = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // 6-bit signed ALU; reserved selects answer with garbage so the sequencer must mask it
   function automatic logic [6:0] alu_ref(input logic [2:0] op, input logic [5:0] a,
                                          input logic [5:0] b);
      logic [5:0] r;
      logic       of;
      r  = 6'd0;
      of = 1'b0;
      case (op)
         3'b000: begin r = a + b; of = (a[5] == b[5]) && (r[5] != a[5]); end
         3'b001: begin r = a - b; of = (a[5] != b[5]) && (r[5] != a[5]); end
         3'b100: r = {5'd0, a == b};
         3'b101: r = {5'd0, $signed(a) > $signed(b)};
         3'b110: r = {5'd0, $signed(a) < $signed(b)};
         3'b111: r = {5'd0, a == 6'd0};
         default: begin r = 6'h3F; of = 1'b1; end
      endcase
      return {of, r};
   endfunction

   function automatic rsp_t model_rsp(input logic [2:0] op, input logic [5:0] a,
                                      input logic [5:0] b);
      rsp_t       e;
      logic [6:0] r;
      r      = alu_ref(op, a, b);
      e.op   = op;
      e.data = (op[2:1] == 2'b01) ? 6'd0 : r[5:0];
      e.of   = (op[2:1] == 2'b01) ? 1'b0 : r[6];
      return e;
   endfunction

   always_comb begin
      {bus.alu_of, bus.alu_returns} = alu_ref(bus.alu_select, bus.alu_a, bus.alu_b);
   end

   // Every cycle: outputs against the model, then log the handshakes of the coming edge
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         ovf_exp    = 0;
         prev_valid = 1'b0;
         chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
         chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
         chk("rst_rsp_of", 32'(bus.rsp_of), 32'd0);
         chk("rst_rsp_op", 32'(bus.rsp_op), 32'd0);
         chk("rst_alu_select", 32'(bus.alu_select), 32'd2);
         chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
         chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
         chk("rst_busy", 32'(bus.busy), 32'd0);
         chk("rst_ovf", 32'(bus.ovf_count), 32'd0);
      end else begin
         if (bus.rsp_valid && !prev_valid && exp_q.size() > 0) begin
            if (exp_q[0].of && ovf_exp != 255) ovf_exp++;
         end
         chk("ovf_count", 32'(bus.ovf_count), 32'(ovf_exp));
         chk("busy", 32'(bus.busy), 32'(exp_q.size() != 0));
         if (exp_q.size() < DEPTH) chk("cmd_ready_open", 32'(bus.cmd_ready), 32'd1);
         if (exp_q.size() > DEPTH) chk("cmd_ready_full", 32'(bus.cmd_ready), 32'd0);
         if (bus.rsp_valid) begin
            chk("rsp_sel_park", 32'(bus.alu_select), 32'd2);
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
            end else begin
               chk("rsp_data", 32'(bus.rsp_data), 32'(exp_q[0].data));
               chk("rsp_of", 32'(bus.rsp_of), 32'(exp_q[0].of));
               chk("rsp_op", 32'(bus.rsp_op), 32'(exp_q[0].op));
            end
         end else if (!bus.busy) begin
            chk("idle_sel_park", 32'(bus.alu_select), 32'd2);
         end
         prev_valid = bus.rsp_valid;
         if (bus.cmd_valid && bus.cmd_ready)
            exp_q.push_back(model_rsp(bus.cmd_op, bus.cmd_a, bus.cmd_b));
         if (bus.rsp_valid && bus.rsp_ready && exp_q.size() > 0) begin
            seen_q.push_back(bus.rsp_data);
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic push_cmd(input logic [2:0] op, input logic [5:0] a, input logic [5:0] b,
                           output int waited);
      logic ok;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      waited        = 0;
      ok            = 1'b0;
      while (!ok && waited <= 200) begin
         @(negedge clk);
         ok = bus.cmd_ready;
         @(posedge clk);
         #1;
         if (!ok) waited++;
      end
      if (!ok) chk("push_timeout", 32'd1, 32'd0);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      @(negedge clk);
      while (!bus.rsp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.rsp_valid) chk("wait_valid_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (bus.busy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy) chk("wait_idle_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      int         w;
      int         vcount;
      logic [6:0] pin;
      logic [5:0] order [6];
      reset         = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'd0;
      bus.cmd_a     = 6'd0;
      bus.cmd_b     = 6'd0;
      bus.rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      pin = alu_ref(3'b000, 6'd5, 6'd3);
      chk("pin_add", 32'(pin), 32'h08);
      pin = alu_ref(3'b000, 6'd31, 6'd1);
      chk("pin_add_ovf", 32'(pin), 32'h60);
      pin = alu_ref(3'b001, 6'h20, 6'd1);
      chk("pin_sub_ovf", 32'(pin), 32'h5F);

      // single add: response visible right after the third edge past acceptance
      push_cmd(3'b000, 6'd5, 6'd3, w);
      @(negedge clk); chk("lat_e1", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk); chk("lat_e2", 32'(bus.rsp_valid), 32'd0);
      chk("issue_sel", 32'(bus.alu_select), 32'd0);
      @(negedge clk); chk("lat_e3", 32'(bus.rsp_valid), 32'd0);
      chk("capture_a", 32'(bus.alu_a), 32'd5);
      chk("capture_b", 32'(bus.alu_b), 32'd3);
      @(negedge clk); chk("lat_e4", 32'(bus.rsp_valid), 32'd1);
      chk("add_data", 32'(bus.rsp_data), 32'd8);
      chk("add_of", 32'(bus.rsp_of), 32'd0);
      chk("add_op", 32'(bus.rsp_op), 32'd0);
      wait_idle();

      push_cmd(3'b000, 6'd31, 6'd1, w);
      wait_valid();
      chk("ovf_rsp_of", 32'(bus.rsp_of), 32'd1);
      chk("ovf_rsp_data", 32'(bus.rsp_data), 32'h20);
      wait_idle();
      chk("ovf_count_1", 32'(bus.ovf_count), 32'd1);

      push_cmd(3'b011, 6'd9, 6'd9, w);
      wait_valid();
      chk("rsv_data", 32'(bus.rsp_data), 32'd0);
      chk("rsv_of", 32'(bus.rsp_of), 32'd0);
      chk("rsv_op", 32'(bus.rsp_op), 32'd3);
      wait_idle();
      chk("rsv_ovf_kept", 32'(bus.ovf_count), 32'd1);

      // back-pressure: one command parked in RESP, four fill the FIFO, the fifth stalls
      seen_q.delete();
      bus.rsp_ready = 1'b0;
      push_cmd(3'b001, 6'd10, 6'd4, w);
      wait_valid();
      @(posedge clk); #1;
      push_cmd(3'b100, 6'd7, 6'd7, w); chk("bp_c1_wait", 32'(w), 32'd0);
      push_cmd(3'b101, 6'd3, 6'd9, w); chk("bp_c2_wait", 32'(w), 32'd0);
      push_cmd(3'b110, 6'd3, 6'd9, w); chk("bp_c3_wait", 32'(w), 32'd0);
      push_cmd(3'b111, 6'd0, 6'd5, w); chk("bp_c4_wait", 32'(w), 32'd0);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'b001;
      bus.cmd_a     = 6'h20;
      bus.cmd_b     = 6'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_full_ready", 32'(bus.cmd_ready), 32'd0);
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      push_cmd(3'b001, 6'h20, 6'd1, w);
      wait_idle();
      chk("bp_drained", 32'(exp_q.size()), 32'd0);
      chk("bp_count", 32'(seen_q.size()), 32'd6);
      order = '{6'd6, 6'd1, 6'd0, 6'd1, 6'd1, 6'h1F};
      for (int i = 0; i < 6; i++) begin
         if (i < seen_q.size()) chk("bp_order", 32'(seen_q[i]), 32'(order[i]));
      end
      chk("bp_ovf", 32'(bus.ovf_count), 32'd2);

      // reset while the first command is in CAPTURE and two more wait in the FIFO
      push_cmd(3'b000, 6'd1, 6'd2, w);
      push_cmd(3'b000, 6'd2, 6'd2, w);
      push_cmd(3'b000, 6'd3, 6'd2, w);
      chk("pre_rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_now_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_now_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_now_busy", 32'(bus.busy), 32'd0);
      chk("rst_now_sel", 32'(bus.alu_select), 32'd2);
      chk("rst_now_a", 32'(bus.alu_a), 32'd0);
      chk("rst_now_ovf", 32'(bus.ovf_count), 32'd0);
      @(posedge clk); #1;
      reset  = 1'b0;
      vcount = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) vcount++;
      end
      chk("post_rst_no_rsp", 32'(vcount), 32'd0);
      chk("post_rst_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 256; i++) begin
         push_cmd(3'b000, 6'd31, 6'd1, w);
      end
      wait_idle();
      chk("ovf_saturated", 32'(bus.ovf_count), 32'd255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
